mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive dcache grants while an icache request waits.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports iREN  input  1 and iaddr  input  32: icache read request and word address.
REQ-006 SHALL have ports iwait  output  1 and iload  output  32: icache stall and returned word.
REQ-007 SHALL have ports dREN  input  1, dWEN  input  1, daddr  input  32, dstore  input  32: dcache request, address, write data.
REQ-008 SHALL have ports dwait  output  1 and dload  output  32: dcache stall and returned word.
REQ-009 SHALL have ports ramREN  output  1, ramWEN  output  1, ramaddr  output  32, ramstore  output  32: single shared RAM port.
REQ-010 SHALL have ports ramstate  input  ramstate_t (FREE/BUSY/ACCESS/ERROR) and ramload  input  32.

Function
REQ-011 SHALL implement states IDLE, IGRANT, DGRANT; RAM enables asserted only in IGRANT/DGRANT.
REQ-012 IDLE: dcache request (dREN|dWEN) and not starving -> DGRANT; else iREN -> IGRANT; else stay; "starving" = iREN && starve_cnt == STARVE_LIMIT.
REQ-013 Grant latency: request visible in cycle N -> RAM enable asserted in cycle N+1.
REQ-014 In DGRANT, ramaddr=daddr, ramstore=dstore; dWEN&&dREN drives ramWEN=1, ramREN=0 (write wins).
REQ-015 In IGRANT, ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-016 iload and dload SHALL equal ramload combinationally at all times.
REQ-017 dwait=0 only in cycle DGRANT && ramstate==ACCESS; iwait=0 only in cycle IGRANT && ramstate==ACCESS; otherwise both 1.
REQ-018 On ACCESS in a grant state, next state SHALL be IDLE (one idle bubble between transactions).
REQ-019 ramstate BUSY or ERROR SHALL hold the grant and keep wait high (RAM retries).
REQ-020 Granted requester dropping its enable mid-grant -> IDLE next cycle, no completion counted.
REQ-021 starve_cnt (width clog2(STARVE_LIMIT+1)) increments on each dcache completion while iREN=1, saturates at STARVE_LIMIT, clears on icache completion or whenever iREN=0.
REQ-022 Requests arriving while a grant is active SHALL be held off by wait=1 and arbitrated in the next IDLE.

Reset
REQ-023 nRST low SHALL asynchronously force state=IDLE, starve_cnt=0, counters=0.
REQ-024 During reset ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-025 Reset asserted mid-grant SHALL abort the transaction with no completion signalled.

Configuration
REQ-026 Macro MEM_ARBITER_PERF_EN defined SHALL add outputs icnt, dcnt, stallcnt (each CNT_W): icache completions, dcache completions, cycles with any wait=1 while its request enable=1; all wrap at 2^CNT_W.
REQ-027 Without MEM_ARBITER_PERF_EN those ports and registers SHALL not exist; arbitration behaviour identical.

Structure
REQ-028 arb_state_t (IDLE/IGRANT/DGRANT) SHALL live in cache_pkg; ramstate_t and word_t come from cpu_types_pkg.
REQ-029 No sub-module; single module with registered next-state and starve counter, combinational output decode.

Verification
REQ-030 Single icache read: iREN=1, iaddr=0x100, ramstate ACCESS on 2nd granted cycle, ramload=0xDEADBEEF -> ramREN at N+1, iwait=0 for one cycle with iload=0xDEADBEEF, state IDLE after.
REQ-031 Simultaneous iREN and dREN at cycle 0 -> DGRANT first, IGRANT after dcache ACCESS plus one IDLE cycle.
REQ-032 Starvation: iREN held, dREN reasserted every IDLE, STARVE_LIMIT=4 -> exactly 4 dcache completions, then icache granted, starve_cnt back to 0.
REQ-033 dREN=dWEN=1, daddr=0x200, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; ERROR for 3 cycles then ACCESS -> dwait low only on ACCESS cycle.
REQ-034 nRST pulsed low in DGRANT with ramstate=BUSY -> ramREN/ramWEN drop immediately, dwait=1, IDLE on release; with MEM_ARBITER_PERF_EN, dcnt=0.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Types local to the cache/memory side of the CPU. arb_state_t is the state
// of the instruction/data cache arbiter in front of the single RAM port.
// ---------------------------------------------------------------------------
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

endpackage : cache_pkg

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-side types: the 32-bit word and the RAM handshake state that the
// memory reports back to whoever currently drives the shared RAM port.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // FREE: idle, BUSY: working, ACCESS: data/ack valid this cycle,
   // ERROR: transient failure, the requester keeps the request up and retries.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates one shared RAM port between the icache (read only) and the
// dcache (read/write). The dcache has priority, except that after
// STARVE_LIMIT back-to-back dcache completions with the icache waiting, the
// icache is granted next. Every transaction is followed by one IDLE cycle.
//
// Parameters
//   STARVE_LIMIT : max consecutive dcache grants while iREN waits (>= 1)
//   CNT_W        : width of the optional performance counters (>= 1)
//
// Ports
//   CLK, nRST                       clock (rising edge), async active-low reset
//   iREN, iaddr / iwait, iload      icache request and response
//   dREN, dWEN, daddr, dstore       dcache request (dWEN wins over dREN)
//   dwait, dload                    dcache response
//   ramREN, ramWEN, ramaddr,
//   ramstore                        shared RAM request port
//   ramstate, ramload               RAM handshake state and read data
//   icnt, dcnt, stallcnt            performance counters, only present when
//                                   MEM_ARBITER_PERF_EN is defined
//
// Build option: `define MEM_ARBITER_PERF_EN adds the counter outputs.
// ---------------------------------------------------------------------------
module mem_arbiter
   import cpu_types_pkg::*;
   import cache_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic      CLK,
   input  logic      nRST,
   // icache side
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   // dcache side
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   // shared RAM port
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  ramstate_t ramstate,
   input  word_t     ramload
`ifdef MEM_ARBITER_PERF_EN
   ,
   output logic [CNT_W-1:0] icnt,
   output logic [CNT_W-1:0] dcnt,
   output logic [CNT_W-1:0] stallcnt
`endif
);

   localparam int unsigned     SC_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

   // Elaboration-time guard on parameter values.
   if ((STARVE_LIMIT < 32'd1) || (CNT_W < 32'd1)) begin : g_param_check
      $error("mem_arbiter: STARVE_LIMIT and CNT_W must both be at least 1");
   end

   arb_state_t      state_q, state_d;
   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

   logic d_req_s;
   logic starving_s;
   logic i_done_s;
   logic d_done_s;

   assign d_req_s    = dREN | dWEN;
   assign starving_s = iREN && (starve_cnt_q == SC_MAX);
   // A completion needs the requester still asserting its enable; a dropped
   // request that happens to meet an ACCESS is not counted.
   assign i_done_s   = (state_q == IGRANT) && iREN    && (ramstate == ACCESS);
   assign d_done_s   = (state_q == DGRANT) && d_req_s && (ramstate == ACCESS);

   // Next-state arbitration.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (d_req_s && !starving_s) begin
               state_d = DGRANT;
            end else if (iREN) begin
               state_d = IGRANT;
            end else begin
               state_d = IDLE;
            end
         end
         // BUSY/ERROR hold the grant; ACCESS or a dropped request ends it.
         IGRANT: begin
            if (!iREN || (ramstate == ACCESS)) begin
               state_d = IDLE;
            end else begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            if (!d_req_s || (ramstate == ACCESS)) begin
               state_d = IDLE;
            end else begin
               state_d = DGRANT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Starvation counter: counts dcache completions seen by a waiting icache.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!iREN || i_done_s) begin
         starve_cnt_d = '0;
      end else if (d_done_s && (starve_cnt_q != SC_MAX)) begin
         starve_cnt_d = starve_cnt_q + SC_W'(1);
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // State and starvation counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // RAM port decode from the registered grant state.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state_q)
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
         end
         DGRANT: begin
            // A write+read request is issued as a write.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         default: begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
         end
      endcase
   end

   assign iwait = !((state_q == IGRANT) && (ramstate == ACCESS));
   assign dwait = !((state_q == DGRANT) && (ramstate == ACCESS));
   assign iload = ramload;
   assign dload = ramload;

`ifdef MEM_ARBITER_PERF_EN
   logic [CNT_W-1:0] icnt_q, dcnt_q, stallcnt_q;
   logic             stall_s;

   // One stall count per cycle in which either requester is held off.
   assign stall_s = (iwait && iREN) || (dwait && d_req_s);

   // Performance counters; all wrap naturally at 2^CNT_W.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         icnt_q     <= '0;
         dcnt_q     <= '0;
         stallcnt_q <= '0;
      end else begin
         if (i_done_s) begin
            icnt_q <= icnt_q + CNT_W'(1);
         end
         if (d_done_s) begin
            dcnt_q <= dcnt_q + CNT_W'(1);
         end
         if (stall_s) begin
            stallcnt_q <= stallcnt_q + CNT_W'(1);
         end
      end
   end

   assign icnt     = icnt_q;
   assign dcnt     = dcnt_q;
   assign stallcnt = stallcnt_q;
`endif

endmodule : mem_arbiter
